// File: rtl/frame_flip_controller_pkg.sv
// illusion_display_pkg: display geometry constants and the flip controller state type
package illusion_display_pkg;
  localparam int FB_WIDTH = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_SIZE = FB_WIDTH * FB_HEIGHT;
  localparam int COORD_W = 10;
  typedef enum logic [1:0] {RENDER, WAIT_SYNC, FLIP, WAIT_RELEASE} flip_state_t;
endpackage

// File: rtl/frame_flip_controller_if.sv
// frame_flip_controller_if: renderer/scan inputs and framebuffer control outputs; FLIP_STATS_EN adds anOutRepeatCount
interface frame_flip_controller_if
  import illusion_display_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int COUNT_W = 16
);
  logic aFrameDone;
  logic [COORD_W-1:0] aX;
  logic [COORD_W-1:0] aY;
  logic anOutFrameFlipped;
  logic [ADDR_W-1:0] anOutWriteBase;
  logic [ADDR_W-1:0] anOutReadBase;
  logic anOutWriteEnable;
  logic [COUNT_W-1:0] anOutFrameCount;
`ifdef FLIP_STATS_EN
  logic [COUNT_W-1:0] anOutRepeatCount;
  modport master (output aFrameDone, aX, aY, input anOutFrameFlipped, anOutWriteBase, anOutReadBase, anOutWriteEnable, anOutFrameCount, anOutRepeatCount);
  modport slave (input aFrameDone, aX, aY, output anOutFrameFlipped, anOutWriteBase, anOutReadBase, anOutWriteEnable, anOutFrameCount, anOutRepeatCount);
`else
  modport master (output aFrameDone, aX, aY, input anOutFrameFlipped, anOutWriteBase, anOutReadBase, anOutWriteEnable, anOutFrameCount);
  modport slave (input aFrameDone, aX, aY, output anOutFrameFlipped, anOutWriteBase, anOutReadBase, anOutWriteEnable, anOutFrameCount);
`endif
endinterface

// File: rtl/frame_flip_controller_scan_point_detector.sv
// scan_point_detector: one-cycle event when the scan position first arrives at (X, Y)
module scan_point_detector
  import illusion_display_pkg::*;
#(
  parameter int X = 0,
  parameter int Y = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic hit
);
  logic match, prev_match_d, prev_match_q;
  always_comb begin
    match = x == COORD_W'(X) && y == COORD_W'(Y);
    prev_match_d = match;
    hit = match && !prev_match_q;
  end
  always_ff @(posedge clk) prev_match_q <= rst ? 1'b1 : prev_match_d;
endmodule

// File: rtl/frame_flip_controller.sv
// frame_flip_controller: double-buffer swap at the scan flip point; FLIP_STATS_EN adds a saturating repeat counter
module frame_flip_controller #(
  parameter int FB_SIZE = illusion_display_pkg::FB_SIZE,
  parameter int ADDR_W = 18,
  parameter int FLIP_X = 0,
  parameter int FLIP_Y = 0,
  parameter int COUNT_W = 16
) (
  input logic aClock,
  input logic aReset,
  frame_flip_controller_if.slave bus
);
  import illusion_display_pkg::*;
  flip_state_t state_d, state_q;
  logic sel_d, sel_q, hit;
  logic [COUNT_W-1:0] frame_cnt_d, frame_cnt_q;
  scan_point_detector #(.X(FLIP_X), .Y(FLIP_Y)) u_scan (
    .clk(aClock), .rst(!aReset), .x(bus.aX), .y(bus.aY), .hit(hit)
  );
  always_comb begin
    state_d = state_q == RENDER ? (bus.aFrameDone ? WAIT_SYNC : RENDER)
            : state_q == WAIT_SYNC ? (hit ? FLIP : WAIT_SYNC)
            : state_q == FLIP ? WAIT_RELEASE
            : bus.aFrameDone ? WAIT_RELEASE : RENDER;
    sel_d = sel_q ^ (state_d == FLIP);
    frame_cnt_d = frame_cnt_q + COUNT_W'(state_d == FLIP);
  end
  always_ff @(posedge aClock) begin
    state_q <= !aReset ? RENDER : state_d;
    sel_q <= !aReset ? 1'b0 : sel_d;
    frame_cnt_q <= !aReset ? '0 : frame_cnt_d;
  end
  assign bus.anOutFrameFlipped = state_q == FLIP;
  assign bus.anOutWriteEnable = state_q == RENDER;
  assign bus.anOutWriteBase = sel_q ? ADDR_W'(FB_SIZE) : '0;
  assign bus.anOutReadBase = sel_q ? '0 : ADDR_W'(FB_SIZE);
  assign bus.anOutFrameCount = frame_cnt_q;
`ifdef FLIP_STATS_EN
  logic [COUNT_W-1:0] rpt_cnt_d, rpt_cnt_q;
  always_comb rpt_cnt_d = rpt_cnt_q + COUNT_W'(state_q == RENDER && hit && rpt_cnt_q != '1);
  always_ff @(posedge aClock) rpt_cnt_q <= !aReset ? '0 : rpt_cnt_d;
  assign bus.anOutRepeatCount = rpt_cnt_q;
`endif
endmodule

// File: tb/tb_frame_flip_controller.sv
// tb_frame_flip_controller: scoreboard bench with a behavioural flip model; FLIP_STATS_EN enables repeat-count checks
module tb_frame_flip_controller;
  localparam int FB = 76800;
  localparam int CW = 4;
  typedef struct {
    logic we;
    logic ff;
    logic [17:0] wb;
    logic [17:0] rb;
    logic [CW-1:0] fc;
    logic [CW-1:0] rc;
  } exp_t;
  typedef struct {
    logic [17:0] wb;
    logic [17:0] rb;
    logic [CW-1:0] fc;
  } flip_t;
  logic aClock = 1'b0;
  logic aReset;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  flip_t flip_q[$];
  int ph, sel, fcnt, rcnt;
  bit prev;
  frame_flip_controller_if #(.ADDR_W(18), .COUNT_W(CW)) bus ();
  frame_flip_controller #(
    .FB_SIZE(FB), .ADDR_W(18), .FLIP_X(0), .FLIP_Y(0), .COUNT_W(CW)
  ) dut (
    .aClock(aClock), .aReset(aReset), .bus(bus)
  );
  always #5 aClock = ~aClock;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, want, $time);
    end
  endtask
  task automatic step(input bit rn, input bit fd, input int x, input int y);
    bit m, ev;
    exp_t e;
    flip_t f;
    aReset = rn;
    bus.aFrameDone = fd;
    bus.aX = 10'(x);
    bus.aY = 10'(y);
    m = x == 0 && y == 0;
    if (!rn) begin
      ph = 0; sel = 0; fcnt = 0; rcnt = 0; prev = 1;
    end else begin
      ev = m && !prev;
      prev = m;
      if (ph == 0) begin
        if (ev && rcnt < (1 << CW) - 1) rcnt++;
        if (fd) ph = 1;
      end else if (ph == 1) begin
        if (ev) begin
          ph = 2;
          sel = 1 - sel;
          fcnt = (fcnt + 1) % (1 << CW);
          f.wb = 18'(sel ? FB : 0);
          f.rb = 18'(sel ? 0 : FB);
          f.fc = CW'(fcnt);
          flip_q.push_back(f);
        end
      end else if (ph == 2) ph = 3;
      else if (!fd) ph = 0;
    end
    e.we = ph == 0;
    e.ff = ph == 2;
    e.wb = 18'(sel ? FB : 0);
    e.rb = 18'(sel ? 0 : FB);
    e.fc = CW'(fcnt);
    e.rc = CW'(rcnt);
    exp_q.push_back(e);
    @(posedge aClock);
    #1;
  endtask
  initial begin
    exp_t e;
    flip_t f;
    forever begin
      @(posedge aClock);
      @(negedge aClock);
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      chk("write_enable", 32'(bus.anOutWriteEnable), 32'(e.we));
      chk("frame_flipped", 32'(bus.anOutFrameFlipped), 32'(e.ff));
      chk("write_base", 32'(bus.anOutWriteBase), 32'(e.wb));
      chk("read_base", 32'(bus.anOutReadBase), 32'(e.rb));
      chk("frame_count", 32'(bus.anOutFrameCount), 32'(e.fc));
`ifdef FLIP_STATS_EN
      chk("repeat_count", 32'(bus.anOutRepeatCount), 32'(e.rc));
`endif
      if (bus.anOutFrameFlipped === 1'b1) begin
        if (flip_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_flip: got pulse expected none at %0t", $time);
        end else begin
          f = flip_q.pop_front();
          chk("flip_write_base", 32'(bus.anOutWriteBase), 32'(f.wb));
          chk("flip_read_base", 32'(bus.anOutReadBase), 32'(f.rb));
          chk("flip_count", 32'(bus.anOutFrameCount), 32'(f.fc));
        end
      end
    end
  end
  initial begin
    bit fd_r, rn;
    int x, y;
    fd_r = 0; x = 5; y = 5;
    step(0, 0, 5, 5); step(0, 0, 5, 5);
    step(1, 1, 100, 50); step(1, 1, 100, 50); step(1, 1, 7, 3);
    step(1, 1, 0, 0); step(1, 1, 1, 0); step(1, 1, 2, 0);
    step(1, 0, 3, 0); step(1, 0, 4, 0);
    step(1, 1, 3, 3); step(1, 1, 3, 3);
    repeat (8) step(1, 1, 0, 0);
    step(1, 1, 5, 5); step(1, 1, 0, 0); step(1, 1, 6, 6); step(1, 1, 0, 0); step(1, 1, 7, 7);
    step(1, 0, 7, 7); step(1, 0, 7, 7);
    repeat (20) begin step(1, 0, 0, 0); step(1, 0, 1, 1); end
    step(1, 1, 4, 4); step(1, 1, 0, 0); step(1, 0, 4, 4); step(1, 0, 4, 4);
    step(1, 1, 2, 2); step(1, 1, 2, 2); step(0, 1, 2, 2);
    step(1, 0, 2, 2); step(1, 0, 0, 0); step(1, 0, 3, 3); step(1, 0, 0, 0); step(1, 0, 3, 3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 10) fd_r = !fd_r;
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          x = 0; y = 0;
        end else begin
          x = $urandom_range(0, 319); y = $urandom_range(0, 239);
        end
      end
      rn = $urandom_range(0, 299) != 0;
      step(rn, fd_r, x, y);
    end
    step(1, 0, 9, 9); step(1, 0, 9, 9);
    @(negedge aClock);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("pending_flips", 32'(flip_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
